seq_gen_lr: RTL and testbench

- Parametrised linear-recurrence sequence generator; successor to the fixed 3-term, 32-bit free-running sequence generator.
- Holds DEPTH history registers and produces next = sum of history elements selected by a runtime tap mask.
- Seeds, taps and sequence length are loaded by a start pulse; elements stream out over a valid/ready interface.
- Configurable overflow handling (wrap or saturate) with a sticky overflow flag.
- Used as a programmable test-pattern/sequence source (Fibonacci, Padovan, Perrin, tribonacci, ...).

---
 rtl/seq_gen_lr.sv | 119 +++++++++++
 tb/tb_seq_gen_lr.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_lr.sv
// seq_gen_lr: programmable linear-recurrence source; emits h[0] and shifts in a tap-selected sum.
// Latency: first element is presented the cycle after start_i, then one element per accepted handshake.
// Backpressure: h, count_o and out_data_o hold while out_valid_o=1 and out_ready_i=0; no output depends combinationally on out_ready_i.
module seq_gen_lr #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16,
  parameter int SAT   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [DEPTH*WIDTH-1:0] seed_i,
  input  logic [DEPTH-1:0]       taps_i,
  input  logic [CNT_W-1:0]       len_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_data_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   ovf_o
);

  // Sum is wide enough that adding all DEPTH elements can never lose a carry.
  localparam int SUM_W = WIDTH + $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] h [DEPTH];   // h[0] oldest (presented), h[DEPTH-1] newest
  logic [DEPTH-1:0] taps_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic [SUM_W-1:0] sum_full;
  logic             sum_ovf;
  logic [WIDTH-1:0] next_val;
  logic             xfer;
  logic [CNT_W-1:0] count_inc;
  logic             last_xfer;

  // Tap-selected sum of the current history at full precision.
  always_comb begin
    sum_full = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (taps_q[k]) begin
        sum_full = sum_full + SUM_W'(h[k]);
      end
    end
  end

  assign sum_ovf   = |sum_full[SUM_W-1:WIDTH];
  assign next_val  = ((SAT != 0) && sum_ovf) ? '1 : sum_full[WIDTH-1:0];
  assign xfer      = (state == RUN) && out_ready_i;
  assign count_inc = count_q + CNT_W'(1);
  // len of zero means free-running: the run only ends on start_i or reset.
  assign last_xfer = (len_q != '0) && (count_inc == len_q);

  // FSM, history shift register and registered status outputs; start_i outranks a same-cycle handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      taps_q  <= '0;
      len_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        h[k] <= '0;
      end
    end else if (start_i) begin
      state   <= RUN;
      valid_q <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      taps_q  <= taps_i;
      len_q   <= len_i;
      for (int k = 0; k < DEPTH; k++) begin
        h[k] <= seed_i[k*WIDTH +: WIDTH];
      end
    end else if (xfer) begin
      for (int k = 0; k < DEPTH-1; k++) begin
        h[k] <= h[k+1];
      end
      h[DEPTH-1] <= next_val;
      count_q    <= count_inc;
      if (sum_ovf) begin
        ovf_q <= 1'b1;
      end
      if (last_xfer) begin
        state   <= DONE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = h[0];
  assign count_o     = count_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_seq_gen_lr.sv
// Bench for seq_gen_lr: three instances (32-bit wrap, 8-bit wrap, 8-bit saturate) share one stimulus stream.
// Expected elements come from a sliding-window recurrence model and are popped by a negedge monitor.
// Directed cases (Padovan, Fibonacci with backpressure, overflow, restart, async reset) plus random runs.
module tb_seq_gen_lr;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [95:0] seed_a;
  logic [23:0] seed_b;
  logic [2:0]  taps;
  logic [15:0] len;
  logic        ready;

  logic        va, vb, vc;
  logic [31:0] da;
  logic [7:0]  db, dc;
  logic [15:0] ca, cb, cc;
  logic        ba, bb, bc;
  logic        dna, dnb, dnc;
  logic        oa, ob, oc;

  int     checks   = 0;
  int     failures = 0;
  longint qa[$], qb[$], qc[$];
  longint mseq[$];
  longint sa[3], sb[3];
  bit     exp_ovf_a, exp_ovf_b, exp_ovf_c;

  logic        pv = 1'b0, pr = 1'b0, ps = 1'b0;
  logic [31:0] pd = '0;

  always #5 clk = ~clk;

  seq_gen_lr #(.WIDTH(32), .DEPTH(3), .CNT_W(16), .SAT(0)) u_a (
    .clk(clk), .reset(reset), .start_i(start), .seed_i(seed_a), .taps_i(taps), .len_i(len),
    .out_valid_o(va), .out_ready_i(ready), .out_data_o(da), .count_o(ca),
    .busy_o(ba), .done_o(dna), .ovf_o(oa));

  seq_gen_lr #(.WIDTH(8), .DEPTH(3), .CNT_W(16), .SAT(0)) u_b (
    .clk(clk), .reset(reset), .start_i(start), .seed_i(seed_b), .taps_i(taps), .len_i(len),
    .out_valid_o(vb), .out_ready_i(ready), .out_data_o(db), .count_o(cb),
    .busy_o(bb), .done_o(dnb), .ovf_o(ob));

  seq_gen_lr #(.WIDTH(8), .DEPTH(3), .CNT_W(16), .SAT(1)) u_c (
    .clk(clk), .reset(reset), .start_i(start), .seed_i(seed_b), .taps_i(taps), .len_i(len),
    .out_valid_o(vc), .out_ready_i(ready), .out_data_o(dc), .count_o(cc),
    .busy_o(bc), .done_o(dnc), .ovf_o(oc));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Recurrence model: the output stream is a list where each new entry is the
  // tap-weighted sum of the DEPTH entries starting at the current head.
  task automatic build_model(input int w, input bit sat, input longint s0, input longint s1,
                             input longint s2, input logic [2:0] tp, input int n, output bit ovf);
    longint s[$];
    longint maxv, sum, val;
    maxv = (longint'(1) << w) - 1;
    s = {s0, s1, s2};
    mseq.delete();
    ovf = 1'b0;
    for (int j = 0; j < n; j++) begin
      sum = 0;
      for (int k = 0; k < 3; k++) if (tp[k]) sum += s[j+k];
      if (sum > maxv) begin
        ovf = 1'b1;
        val = sat ? maxv : (sum & maxv);
      end else begin
        val = sum;
      end
      s.push_back(val);
      mseq.push_back(s[j]);
    end
  endtask

  task automatic set_seeds(input longint a0, input longint a1, input longint a2,
                           input longint b0, input longint b1, input longint b2);
    sa[0] = a0; sa[1] = a1; sa[2] = a2;
    sb[0] = b0; sb[1] = b1; sb[2] = b2;
    seed_a = {32'(a2), 32'(a1), 32'(a0)};
    seed_b = {8'(b2), 8'(b1), 8'(b0)};
  endtask

  // Pulse start for one cycle, then replace every scoreboard queue with the new run.
  task automatic pulse_start();
    int n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = (len == 16'd0) ? 64 : int'(len);
    build_model(32, 1'b0, sa[0], sa[1], sa[2], taps, n, exp_ovf_a); qa = mseq;
    build_model(8,  1'b0, sb[0], sb[1], sb[2], taps, n, exp_ovf_b); qb = mseq;
    build_model(8,  1'b1, sb[0], sb[1], sb[2], taps, n, exp_ovf_c); qc = mseq;
  endtask

  // rmode: 0 ready held high, 1 toggling, 2 random (~75% high).
  task automatic wait_done(input int maxc, input int rmode, output int cyc);
    cyc = 0;
    while (!dna && cyc < maxc) begin
      if (rmode == 1)      ready = ~ready;
      else if (rmode == 2) ready = ($urandom_range(0, 3) != 0);
      else                 ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!dna) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", cyc);
    end
  endtask

  task automatic end_checks(input string tag, input int n);
    check({tag, "_count_a"}, ca, n);
    check({tag, "_count_b"}, cb, n);
    check({tag, "_count_c"}, cc, n);
    check({tag, "_done"}, {dna, dnb, dnc}, 3'b111);
    check({tag, "_valid"}, {va, vb, vc}, 3'b000);
    check({tag, "_busy"}, {ba, bb, bc}, 3'b000);
    check({tag, "_ovf"}, {oa, ob, oc}, {exp_ovf_a, exp_ovf_b, exp_ovf_c});
  endtask

  task automatic zero_checks(input string tag);
    check({tag, "_valid"}, {va, vb, vc}, 0);
    check({tag, "_busy"}, {ba, bb, bc}, 0);
    check({tag, "_done"}, {dna, dnb, dnc}, 0);
    check({tag, "_ovf"}, {oa, ob, oc}, 0);
    check({tag, "_data"}, {da, db, dc}, 0);
    check({tag, "_count"}, {ca, cb, cc}, 0);
  endtask

  // Monitor: every accepted element is popped and compared; held elements must not move.
  always @(negedge clk) begin
    if (!reset) begin
      if (va && ready) begin
        if (qa.size() == 0) begin checks++; failures++; $display("FAIL data_a: got %0d expected nothing", da); end
        else check("data_a", da, qa.pop_front());
      end
      if (vb && ready) begin
        if (qb.size() == 0) begin checks++; failures++; $display("FAIL data_b: got %0d expected nothing", db); end
        else check("data_b", db, qb.pop_front());
      end
      if (vc && ready) begin
        if (qc.size() == 0) begin checks++; failures++; $display("FAIL data_c: got %0d expected nothing", dc); end
        else check("data_c", dc, qc.pop_front());
      end
      if (pv && !pr && !ps && va) check("hold_a", da, pd);
    end
    pv = va && !reset;
    pr = ready;
    ps = start;
    pd = da;
  end

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    taps  = '0;
    len   = '0;
    set_seeds(0, 0, 0, 0, 0, 0);
    #1;
    zero_checks("reset");
    #11 reset = 1'b0;
    @(posedge clk); #1;

    // Padovan, ready held high.
    set_seeds(0, 1, 1, 0, 1, 1);
    taps = 3'b011; len = 16'd10; ready = 1'b1;
    pulse_start();
    check("pad_first", da, 0);
    wait_done(100, 0, cyc);
    check("pad_cycles", cyc, 10);
    end_checks("pad", 10);

    // Fibonacci with ready toggling 1,0,1,0...
    set_seeds(0, 1, 1, 0, 1, 1);
    taps = 3'b110; len = 16'd8; ready = 1'b0;
    pulse_start();
    wait_done(100, 1, cyc);
    check("fib_cycles", cyc, 15);
    end_checks("fib", 8);

    // Fibonacci long enough to overflow the 8-bit instances.
    set_seeds(0, 1, 1, 0, 1, 1);
    taps = 3'b110; len = 16'd16; ready = 1'b1;
    pulse_start();
    wait_done(100, 0, cyc);
    check("ovf_cycles", cyc, 16);
    end_checks("ovf", 16);
    check("ovf_flags", {oa, ob, oc}, 3'b011);

    // Random seeds, taps, lengths and backpressure.
    for (int r = 0; r < 8; r++) begin
      logic [31:0] r0, r1, r2;
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      set_seeds(longint'(r0), longint'(r1), longint'(r2),
                longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)),
                longint'($urandom_range(0, 255)));
      taps = 3'($urandom_range(0, 7));
      len  = 16'($urandom_range(1, 20));
      pulse_start();
      wait_done(400, 2, cyc);
      end_checks("rand", int'(len));
    end

    // Free run, then restart with Perrin seeds on the same cycle as a handshake.
    set_seeds(0, 1, 1, 0, 1, 1);
    taps = 3'b110; len = 16'd0; ready = 1'b1;
    pulse_start();
    repeat (5) begin @(posedge clk); #1; end
    check("free_count5", ca, 5);
    set_seeds(3, 0, 2, 3, 0, 2);
    taps = 3'b011;
    pulse_start();
    check("restart_count", ca, 0);
    check("restart_data", da, 3);
    repeat (12) begin @(posedge clk); #1; end
    check("free_count12", {ca, cb, cc}, {16'd12, 16'd12, 16'd12});
    check("free_busy", {ba, bb, bc}, 3'b111);
    check("free_done", {dna, dnb, dnc}, 3'b000);

    // Asynchronous reset between clock edges during a run.
    #3 reset = 1'b1;
    #1;
    zero_checks("arst");
    @(posedge clk); #1;
    reset = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_valid", {va, vb, vc}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
